// File: rtl/packer_arbiter.sv
// packer_arbiter
// Round-robin owner of the shared 8-bit-in / 32-bit-out byte packer. One
// requester is granted for a whole packed word, so bytes from different
// sources never interleave inside a word. Downstream FIFO backpressure
// freezes the word. A requester that goes quiet mid-word for STALL_MAX
// cycles has the rest of its word padded with PAD_BYTE.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset (also resets the packer)
//   req_valid  : per-requester byte available
//   req_data   : requester i byte at bits [8i+7:8i]
//   req_ready  : byte from requester i accepted this cycle (combinational)
//   fifo_full  : downstream FIFO full, no new byte is issued
//   valid_in   : registered byte strobe to the packer
//   data_in    : registered byte to the packer
//   grant_id   : current word owner, meaningful while busy
//   busy       : a word is in progress (BURST or PAD)
//   word_done  : one-cycle pulse alongside the last byte of a word
//   stall_err  : sticky flag, set when padding occurs, cleared by rst only
module packer_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter int          BYTES_PER_WORD = 4,
    parameter int          STALL_MAX      = 16,
    parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*8-1:0]        req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        valid_in,
    output logic [7:0]                  data_in,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        word_done,
    output logic                        stall_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int SW = $clog2(STALL_MAX + 1);

    localparam logic [BW-1:0] LAST_BYTE  = BW'(BYTES_PER_WORD - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
    localparam logic [SW-1:0] STALL_TOP  = SW'(STALL_MAX);
    localparam logic [GW-1:0] LAST_REQ   = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_PAD   = 2'd2
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last_grant;
    logic [BW-1:0]   r_bcnt;
    logic [SW-1:0]   r_stall_cnt;
    logic            r_valid_in;
    logic [7:0]      r_data_in;
    logic            r_word_done;
    logic            r_stall_err;

    state_t          w_state_nxt;
    logic [GW-1:0]   w_grant_nxt;
    logic [GW-1:0]   w_last_nxt;
    logic [BW-1:0]   w_bcnt_nxt;
    logic [SW-1:0]   w_stall_nxt;
    logic            w_valid_nxt;
    logic [7:0]      w_data_nxt;
    logic            w_wd_nxt;
    logic            w_err_nxt;

    logic            w_found;
    logic [GW-1:0]   w_pick;
    int              w_idx;
    logic            w_gvalid;
    logic [7:0]      w_byte;
    logic            w_xfer;

    // Round-robin search: first valid requester starting after the last owner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_found && req_valid[GW'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = GW'(w_idx);
            end else begin
                w_pick  = w_pick;
            end
        end
    end

    // Mux the owner's valid and byte out of the flat request buses.
    always_comb begin
        w_gvalid = 1'b0;
        w_byte   = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gvalid = w_gvalid | ((r_grant == GW'(i)) & req_valid[i]);
            w_byte   = w_byte | ({8{r_grant == GW'(i)}} & req_data[8*i +: 8]);
        end
    end

    // A byte moves only from the owner, only in BURST, and only when the FIFO has room.
    assign w_xfer = (r_state == ST_BURST) & w_gvalid & ~fifo_full;

    // Ready is one-hot on the owner when a transfer happens, zero otherwise.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (r_grant == GW'(i)) & w_xfer;
        end
    end

    // Next-state and next-output logic of the word FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_grant;
        w_bcnt_nxt  = r_bcnt;
        w_stall_nxt = r_stall_cnt;
        w_valid_nxt = 1'b0;
        w_data_nxt  = r_data_in;
        w_wd_nxt    = 1'b0;
        w_err_nxt   = r_stall_err;
        case (r_state)
            ST_IDLE: begin
                w_bcnt_nxt  = '0;
                w_stall_nxt = '0;
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_BURST;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (w_xfer) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_byte;
                    w_stall_nxt = '0;
                    if (r_bcnt == LAST_BYTE) begin
                        w_wd_nxt    = 1'b1;
                        w_last_nxt  = r_grant;
                        w_bcnt_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bcnt_nxt  = r_bcnt + BW'(1);
                    end
                end else if (!fifo_full) begin
                    // Idle owner with room downstream counts as a stall; the
                    // cycle that would make the count reach STALL_MAX enters PAD.
                    if (r_stall_cnt >= STALL_LAST) begin
                        w_stall_nxt = STALL_TOP;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_PAD;
                    end else begin
                        w_stall_nxt = r_stall_cnt + SW'(1);
                    end
                end else begin
                    // Backpressure is not a stall: hold the count.
                    w_stall_nxt = r_stall_cnt;
                end
            end
            ST_PAD: begin
                if (!fifo_full) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = PAD_BYTE;
                    if (r_bcnt == LAST_BYTE) begin
                        w_wd_nxt    = 1'b1;
                        w_last_nxt  = r_grant;
                        w_bcnt_nxt  = '0;
                        w_stall_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bcnt_nxt  = r_bcnt + BW'(1);
                    end
                end else begin
                    w_bcnt_nxt = r_bcnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; async reset abandons any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= LAST_REQ;
            r_bcnt       <= '0;
            r_stall_cnt  <= '0;
            r_valid_in   <= 1'b0;
            r_data_in    <= 8'h00;
            r_word_done  <= 1'b0;
            r_stall_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_stall_cnt  <= w_stall_nxt;
            r_valid_in   <= w_valid_nxt;
            r_data_in    <= w_data_nxt;
            r_word_done  <= w_wd_nxt;
            r_stall_err  <= w_err_nxt;
        end
    end

    assign valid_in  = r_valid_in;
    assign data_in   = r_data_in;
    assign grant_id  = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign word_done = r_word_done;
    assign stall_err = r_stall_err;

endmodule
